// File: rtl/lfsr_ctrl_pkg.sv
// lfsr_ctrl_pkg
// Shared types and constants for the LFSR bank sequencer.
//   lfsr_state_e  : sequencer FSM states
//   LFSR_W        : width of one LFSR lane / seed
//   SEED_BASE, SEED_STRIDE : power-up seed table generator
//   INIT_CYCLES   : length of the seed-load (INIT) phase
//   seed_default  : power-up seed of lane i
//   seed_sanitize : maps the forbidden all-zero seed to 16'h0001
//   idx_w         : width of a lane index for a given lane count
package lfsr_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } lfsr_state_e;

  localparam int          LFSR_W      = 16;
  localparam logic [15:0] SEED_BASE   = 16'hACE1;
  localparam logic [15:0] SEED_STRIDE = 16'h1F35;
  localparam int          INIT_CYCLES = 2;

  function automatic logic [LFSR_W-1:0] seed_default(input int unsigned idx);
    logic [31:0] prod;
    prod = idx * 32'(SEED_STRIDE);
    return SEED_BASE ^ prod[15:0];
  endfunction

  // An all-zero state locks an LFSR up forever, so it is never stored.
  function automatic logic [LFSR_W-1:0] seed_sanitize(input logic [LFSR_W-1:0] d);
    return (d == 16'h0000) ? 16'h0001 : d;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lfsr_bank_sequencer_if.sv
// lfsr_bank_sequencer_if
// Scheduler-side bus of the LFSR bank sequencer.
//   START/ABORT/LEN/DIV                   : epoch control from the layer scheduler
//   SEED_WR_VALID/IDX/DATA, SEED_WR_READY : seed table write port
//   BUSY/DONE/STREAM_VALID/BIT_CNT        : epoch status back to the scheduler
// Modports: master = scheduler, slave = sequencer.
interface lfsr_bank_sequencer_if #(
  parameter int N_LANES = 4,
  parameter int LEN_W   = 10,
  parameter int DIV_W   = 4
);
  import lfsr_ctrl_pkg::*;

  localparam int IDX_W = idx_w(N_LANES);

  logic              START;
  logic              ABORT;
  logic [LEN_W-1:0]  LEN;
  logic [DIV_W-1:0]  DIV;
  logic              SEED_WR_VALID;
  logic [IDX_W-1:0]  SEED_WR_IDX;
  logic [LFSR_W-1:0] SEED_WR_DATA;
  logic              SEED_WR_READY;
  logic              BUSY;
  logic              DONE;
  logic              STREAM_VALID;
  logic [LEN_W-1:0]  BIT_CNT;

  modport master (
    output START, ABORT, LEN, DIV, SEED_WR_VALID, SEED_WR_IDX, SEED_WR_DATA,
    input  SEED_WR_READY, BUSY, DONE, STREAM_VALID, BIT_CNT
  );

  modport slave (
    input  START, ABORT, LEN, DIV, SEED_WR_VALID, SEED_WR_IDX, SEED_WR_DATA,
    output SEED_WR_READY, BUSY, DONE, STREAM_VALID, BIT_CNT
  );

endinterface

// File: rtl/lfsr_trig_divider.sv
// lfsr_trig_divider
// Loadable down-counter that spaces TRIG strobes one every DIV+1 cycles.
//   CLK, RESET  : clock, asynchronous active-high reset
//   run_en_s    : the coming cycle is a RUN cycle
//   div_s       : latched divider value
//   tick_nxt_s  : TRIG will be high in the coming cycle
//   trig_r      : registered TRIG strobe
// The first RUN cycle always fires; every TRIG reloads the counter with DIV.
module lfsr_trig_divider #(
  parameter int DIV_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             run_en_s,
  input  logic [DIV_W-1:0] div_s,
  output logic             tick_nxt_s,
  output logic             trig_r
);

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] cnt_nxt_s;
  logic             run_r;

  // Next count: zero outside RUN and on RUN entry, reload on TRIG, else count down.
  always_comb begin
    cnt_nxt_s = {DIV_W{1'b0}};
    if (!run_en_s) begin
      cnt_nxt_s = {DIV_W{1'b0}};
    end else if (!run_r) begin
      cnt_nxt_s = {DIV_W{1'b0}};
    end else if (trig_r) begin
      cnt_nxt_s = div_s;
    end else begin
      cnt_nxt_s = cnt_r - DIV_W'(1);
    end
    tick_nxt_s = run_en_s && (cnt_nxt_s == {DIV_W{1'b0}});
  end

  // Counter, RUN-phase flag and TRIG output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_r  <= {DIV_W{1'b0}};
      run_r  <= 1'b0;
      trig_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      run_r  <= run_en_s;
      trig_r <= tick_nxt_s;
    end
  end

endmodule

// File: rtl/lfsr_bank_sequencer.sv
// lfsr_bank_sequencer
// Sequencer for a bank of N_LANES 16-bit LFSR stochastic-number sources.
//   CLK, RESET  : clock, asynchronous active-high reset
//   bus         : scheduler bus (epoch control, seed writes, status)
//   LFSR_SEED   : seed table, lane i at [16i+15:16i]
//   LFSR_INIT   : load-seed strobe (two cycles per epoch)
//   LFSR_TRIG   : one-cycle shift strobe
//   LFSR_RESET  : one-cycle reseed strobe after an abort
// Flow per epoch: IDLE -> INIT -> RUN -> DRAIN -> FIN -> IDLE.
// Status/strobe outputs are flops loaded from the next-state decode, so they
// line up with the state they describe; only SEED_WR_READY decodes state_r.
module lfsr_bank_sequencer
  import lfsr_ctrl_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int LEN_W   = 10,
  parameter int DIV_W   = 4
) (
  input  logic                      CLK,
  input  logic                      RESET,
  lfsr_bank_sequencer_if.slave      bus,
  output logic [LFSR_W*N_LANES-1:0] LFSR_SEED,
  output logic                      LFSR_INIT,
  output logic                      LFSR_TRIG,
  output logic                      LFSR_RESET
);

  localparam int IDX_W = idx_w(N_LANES);

  lfsr_state_e       state_r, state_nxt_s;
  logic [1:0]        init_cnt_r, init_cnt_nxt_s;
  logic [LEN_W-1:0]  len_r, len_nxt_s;
  logic [DIV_W-1:0]  div_r, div_nxt_s;
  logic [LEN_W-1:0]  bit_cnt_r;
  logic              clr_cnt_s;
  logic              lreset_nxt_s;
  logic              busy_r, init_r, done_r, lreset_r, sv_r;
  logic              trig_r, tick_nxt_s;
  logic              idx_ok_s, wr_en_s;
  logic [LFSR_W-1:0] seed_r [N_LANES];

  if ((1 << IDX_W) == N_LANES) begin : g_idx_full
    assign idx_ok_s = 1'b1;
  end else begin : g_idx_part
    assign idx_ok_s = (32'(bus.SEED_WR_IDX) < N_LANES);
  end

  assign bus.SEED_WR_READY = (state_r == IDLE);
  assign wr_en_s           = bus.SEED_WR_VALID && (state_r == IDLE) && idx_ok_s;

  // Next-state logic; ABORT overrides everything and drops a same-cycle START.
  always_comb begin
    state_nxt_s    = state_r;
    init_cnt_nxt_s = init_cnt_r;
    len_nxt_s      = len_r;
    div_nxt_s      = div_r;
    lreset_nxt_s   = 1'b0;
    clr_cnt_s      = 1'b0;
    if (bus.ABORT) begin
      state_nxt_s  = IDLE;
      lreset_nxt_s = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.START) begin
            state_nxt_s    = INIT;
            init_cnt_nxt_s = 2'd0;
            len_nxt_s      = bus.LEN;
            div_nxt_s      = bus.DIV;
            clr_cnt_s      = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        INIT: begin
          if (init_cnt_r == 2'(INIT_CYCLES - 1)) begin
            state_nxt_s = (len_r == {LEN_W{1'b0}}) ? DRAIN : RUN;
          end else begin
            init_cnt_nxt_s = init_cnt_r + 2'd1;
          end
        end
        RUN: begin
          // bit_cnt_r already counts the TRIG on the output this cycle.
          if (trig_r && (bit_cnt_r == len_r)) begin
            state_nxt_s = DRAIN;
          end else begin
            state_nxt_s = RUN;
          end
        end
        DRAIN:   state_nxt_s = FIN;
        FIN:     state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  lfsr_trig_divider #(.DIV_W(DIV_W)) u_div (
    .CLK        (CLK),
    .RESET      (RESET),
    .run_en_s   (state_nxt_s == RUN),
    .div_s      (div_r),
    .tick_nxt_s (tick_nxt_s),
    .trig_r     (trig_r)
  );

  // State, latched epoch parameters and registered status/strobe outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r    <= IDLE;
      init_cnt_r <= 2'd0;
      len_r      <= {LEN_W{1'b0}};
      div_r      <= {DIV_W{1'b0}};
      busy_r     <= 1'b0;
      init_r     <= 1'b0;
      done_r     <= 1'b0;
      lreset_r   <= 1'b0;
      sv_r       <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      init_cnt_r <= init_cnt_nxt_s;
      len_r      <= len_nxt_s;
      div_r      <= div_nxt_s;
      busy_r     <= (state_nxt_s inside {INIT, RUN, DRAIN});
      init_r     <= (state_nxt_s == INIT);
      done_r     <= (state_nxt_s == FIN);
      lreset_r   <= lreset_nxt_s;
      // Lane outputs are valid the cycle after a TRIG unless the bank is being reseeded.
      sv_r       <= trig_r && (state_nxt_s != IDLE);
    end
  end

  // TRIG counter: cleared on accepted START, counts alongside each TRIG, holds otherwise.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bit_cnt_r <= {LEN_W{1'b0}};
    end else if (clr_cnt_s) begin
      bit_cnt_r <= {LEN_W{1'b0}};
    end else if (tick_nxt_s) begin
      bit_cnt_r <= bit_cnt_r + LEN_W'(1);
    end else begin
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Seed table: generated defaults on reset, sanitized writes accepted only in IDLE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < N_LANES; i++) begin
        seed_r[i] <= seed_default(i);
      end
    end else if (wr_en_s) begin
      seed_r[bus.SEED_WR_IDX] <= seed_sanitize(bus.SEED_WR_DATA);
    end
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_seed_out
    assign LFSR_SEED[LFSR_W*g +: LFSR_W] = seed_r[g];
  end

  assign LFSR_INIT        = init_r;
  assign LFSR_TRIG        = trig_r;
  assign LFSR_RESET       = lreset_r;
  assign bus.BUSY         = busy_r;
  assign bus.DONE         = done_r;
  assign bus.STREAM_VALID = sv_r;
  assign bus.BIT_CNT      = bit_cnt_r;

endmodule

// File: tb/tb_lfsr_bank_sequencer.sv
// tb_lfsr_bank_sequencer
// Self-checking bench: directed epochs plus randomized epochs, aborts and
// seed writes. Expected per-cycle outputs are computed arithmetically from the
// epoch timeline (START at cycle 0, INIT 1..2, TRIG at 3 + j*(DIV+1)).
module tb_lfsr_bank_sequencer;
  localparam int N_LANES = 4;
  localparam int LEN_W   = 10;
  localparam int DIV_W   = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [63:0] LFSR_SEED;
  logic        LFSR_INIT, LFSR_TRIG, LFSR_RESET;

  lfsr_bank_sequencer_if #(.N_LANES(N_LANES), .LEN_W(LEN_W), .DIV_W(DIV_W)) bus ();

  lfsr_bank_sequencer #(.N_LANES(N_LANES), .LEN_W(LEN_W), .DIV_W(DIV_W)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .bus        (bus),
    .LFSR_SEED  (LFSR_SEED),
    .LFSR_INIT  (LFSR_INIT),
    .LFSR_TRIG  (LFSR_TRIG),
    .LFSR_RESET (LFSR_RESET)
  );

  always #5 CLK = ~CLK;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          prev_cnt = 0;
  logic [15:0] seed_m [N_LANES];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [63:0] seed_flat();
    logic [63:0] f;
    for (int i = 0; i < N_LANES; i++) f[16*i +: 16] = seed_m[i];
    return f;
  endfunction

  // Number of TRIGs issued by the end of epoch cycle k.
  function automatic int n_trig(input int k, input int len, input int dv);
    int n;
    if (len == 0 || k < 3) return 0;
    n = (k - 3) / (dv + 1) + 1;
    return (n < len) ? n : len;
  endfunction

  function automatic int fin_of(input int len, input int dv);
    return (len == 0) ? 4 : 5 + (len - 1) * (dv + 1);
  endfunction

  task automatic check_cycle(input int k, input int len, input int dv, input int ab);
    int fin;
    logic busy, init, trig, sv, done, ready, lrst;
    int cnt;
    fin = fin_of(len, dv);
    if (ab > 0 && k > ab) begin
      lrst = (k == ab + 1); busy = 0; init = 0; trig = 0; sv = 0; done = 0; ready = 1;
      cnt = n_trig(ab, len, dv);
    end else begin
      lrst  = 0;
      busy  = (k >= 1) && (k <= fin - 1);
      init  = (k == 1) || (k == 2);
      trig  = n_trig(k, len, dv) != n_trig(k - 1, len, dv);
      sv    = n_trig(k - 1, len, dv) != n_trig(k - 2, len, dv);
      done  = (k == fin);
      ready = (k == 0) || (k > fin);
      cnt   = (k == 0) ? prev_cnt : n_trig(k, len, dv);
    end
    chk($sformatf("busy@%0d", k),  bus.BUSY, busy);
    chk($sformatf("init@%0d", k),  LFSR_INIT, init);
    chk($sformatf("trig@%0d", k),  LFSR_TRIG, trig);
    chk($sformatf("svalid@%0d", k), bus.STREAM_VALID, sv);
    chk($sformatf("done@%0d", k),  bus.DONE, done);
    chk($sformatf("ready@%0d", k), bus.SEED_WR_READY, ready);
    chk($sformatf("lrst@%0d", k),  LFSR_RESET, lrst);
    chk($sformatf("bitcnt@%0d", k), bus.BIT_CNT, 64'(cnt));
    chk($sformatf("seed@%0d", k),  LFSR_SEED, seed_flat());
  endtask

  task automatic run_epoch(input int len, input int dv, input int ab, input bit wr,
                           input int widx, input logic [15:0] wdata, input bit junk);
    int fin, last;
    fin  = fin_of(len, dv);
    last = (ab > 0) ? ab + 2 : fin + 2;
    @(negedge CLK);
    check_cycle(0, len, dv, ab);
    bus.START = 1'b1;
    bus.LEN   = LEN_W'(len);
    bus.DIV   = DIV_W'(dv);
    if (wr) begin
      bus.SEED_WR_VALID = 1'b1;
      bus.SEED_WR_IDX   = 2'(widx);
      bus.SEED_WR_DATA  = wdata;
      seed_m[widx] = (wdata == 16'h0000) ? 16'h0001 : wdata;
    end
    for (int k = 1; k <= last; k++) begin
      @(posedge CLK);
      #1;
      bus.START = 1'b0; bus.ABORT = 1'b0; bus.SEED_WR_VALID = 1'b0;
      @(negedge CLK);
      check_cycle(k, len, dv, ab);
      bus.ABORT = (k == ab);
      // Traffic that must be ignored while the sequencer is not idle.
      if (junk && k <= fin && (ab == 0 || k <= ab)) begin
        bus.START         = 1'($urandom_range(0, 1));
        bus.LEN           = LEN_W'($urandom_range(0, 7));
        bus.SEED_WR_VALID = 1'b1;
        bus.SEED_WR_IDX   = 2'($urandom_range(0, 3));
        bus.SEED_WR_DATA  = 16'($urandom);
      end
    end
    prev_cnt = (ab > 0) ? n_trig(ab, len, dv) : len;
  endtask

  task automatic seed_write(input int idx, input logic [15:0] d);
    @(negedge CLK);
    chk("ready_idle", bus.SEED_WR_READY, 1'b1);
    bus.SEED_WR_VALID = 1'b1;
    bus.SEED_WR_IDX   = 2'(idx);
    bus.SEED_WR_DATA  = d;
    @(posedge CLK);
    #1;
    bus.SEED_WR_VALID = 1'b0;
    seed_m[idx] = (d == 16'h0000) ? 16'h0001 : d;
    @(negedge CLK);
    chk($sformatf("seed_wr%0d", idx), LFSR_SEED, seed_flat());
  endtask

  task automatic abort_in_idle();
    @(negedge CLK);
    bus.START = 1'b1; bus.ABORT = 1'b1; bus.LEN = LEN_W'(5); bus.DIV = DIV_W'(0);
    @(posedge CLK);
    #1;
    bus.START = 1'b0; bus.ABORT = 1'b0;
    @(negedge CLK);
    chk("idle_abort_lrst", LFSR_RESET, 1'b1);
    chk("idle_abort_busy", bus.BUSY, 1'b0);
    chk("idle_abort_init", LFSR_INIT, 1'b0);
    chk("idle_abort_ready", bus.SEED_WR_READY, 1'b1);
    @(negedge CLK);
    chk("idle_abort_lrst2", LFSR_RESET, 1'b0);
    chk("idle_abort_init2", LFSR_INIT, 1'b0);
    chk("idle_abort_busy2", bus.BUSY, 1'b0);
    chk("idle_abort_cnt", bus.BIT_CNT, 64'(prev_cnt));
  endtask

  initial begin
    int len, dv, ab, widx;
    logic [15:0] wd;
    RESET = 1'b1;
    bus.START = 1'b0; bus.ABORT = 1'b0; bus.LEN = '0; bus.DIV = '0;
    bus.SEED_WR_VALID = 1'b0; bus.SEED_WR_IDX = '0; bus.SEED_WR_DATA = '0;
    seed_m[0] = 16'hACE1; seed_m[1] = 16'hB3D4; seed_m[2] = 16'h928B; seed_m[3] = 16'hF17E;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_seed", LFSR_SEED, 64'hF17E_928B_B3D4_ACE1);
    chk("rst_ready", bus.SEED_WR_READY, 1'b1);
    chk("rst_init", LFSR_INIT, 1'b0);
    chk("rst_trig", LFSR_TRIG, 1'b0);
    chk("rst_lrst", LFSR_RESET, 1'b0);
    chk("rst_busy", bus.BUSY, 1'b0);
    chk("rst_done", bus.DONE, 1'b0);
    chk("rst_sv", bus.STREAM_VALID, 1'b0);
    chk("rst_cnt", bus.BIT_CNT, 64'd0);

    seed_write(1, 16'h0000);
    seed_write(2, 16'h1234);

    run_epoch(3, 0, 0, 1'b0, 0, 16'h0, 1'b1);   // writes during BUSY must be rejected
    run_epoch(2, 2, 0, 1'b0, 0, 16'h0, 1'b0);
    run_epoch(10, 0, 4, 1'b0, 0, 16'h0, 1'b0);  // abort on the 2nd TRIG
    run_epoch(0, 0, 0, 1'b1, 3, 16'h5A5A, 1'b0); // write same cycle as START
    abort_in_idle();

    for (int e = 0; e < 30; e++) begin
      len  = $urandom_range(0, 12);
      dv   = $urandom_range(0, 3);
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, fin_of(len, dv)) : 0;
      widx = $urandom_range(0, 3);
      wd   = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      run_epoch(len, dv, ab, 1'($urandom_range(0, 1)), widx, wd, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
